wdb_entry_alloc: RTL and testbench

- Per-channel free-list allocator for write-data-buffer (WDB) entries.
- Feeds alloc_vld/alloc_idx into the 4-channel write request crossbar and consumes its alloc_rdy handshake.
- Recycles entry indices released by the downstream write-data consumer after the data has been drained.
- Four independent circular FIFOs of free indices, one per crossbar output channel. An init FSM populates them after reset.

---
 rtl/wdb_entry_alloc_if.sv | 28 ++
 rtl/wdb_entry_alloc.sv | 122 ++++++++++++
 tb/tb_wdb_entry_alloc.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wdb_entry_alloc_if.sv
// Allocation / release handshake bundle between the WDB entry allocator
// (master) and the write-request crossbar plus write-data consumer (slave).
interface wdb_entry_alloc_if #(
  parameter int IDX_W  = 6,
  parameter int CH_NUM = 4
);
  logic [CH_NUM-1:0]            alloc_vld;
  logic [CH_NUM-1:0][IDX_W-1:0] alloc_idx;
  logic [CH_NUM-1:0]            alloc_rdy;
  logic [CH_NUM-1:0]            release_vld;
  logic [CH_NUM-1:0][IDX_W-1:0] release_idx;

  modport master (
    output alloc_vld,
    output alloc_idx,
    input  alloc_rdy,
    input  release_vld,
    input  release_idx
  );

  modport slave (
    input  alloc_vld,
    input  alloc_idx,
    output alloc_rdy,
    output release_vld,
    output release_idx
  );
endinterface

// File: rtl/wdb_entry_alloc.sv
// Per-channel free-list allocator for write-data-buffer entries.
// Each channel keeps a circular FIFO of the free indices it owns; a shared
// init FSM fills every FIFO with its channel's index range after reset.
// Offered indices come straight from flops: no release-to-alloc bypass.
module wdb_entry_alloc #(
  parameter int DB_ENTRY_NUM = 64,
  parameter int CH_NUM       = 4,
  localparam int IDX_W = $clog2(DB_ENTRY_NUM),
  localparam int EPC   = DB_ENTRY_NUM / CH_NUM,
  localparam int PW    = $clog2(EPC),
  localparam int CW    = PW + 1,
  localparam int CHW   = $clog2(CH_NUM)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  wdb_entry_alloc_if.master     bus,
  output logic [3:0][CW-1:0]    free_cnt,
  output logic                  init_done,
  output logic [3:0]            err_overflow,
  output logic [3:0]            err_chmis
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_init_cnt;
  logic          r_init_done;
  logic          w_init;
  logic          w_run;

  assign w_init    = (r_state == ST_INIT);
  assign w_run     = (r_state == ST_RUN);
  assign init_done = r_init_done;

  // State register, init slot counter and registered init_done flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      if (w_init) r_init_cnt <= r_init_cnt + PW'(1);
    end
  end

  // Next-state: leave INIT once the last slot of every channel is written
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == PW'(EPC - 1)) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [IDX_W-1:0] r_fifo [EPC];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_err_ovf;
    logic             r_err_chmis;
    logic             w_vld;
    logic             w_pop;
    logic             w_own;
    logic             w_rel;
    logic             w_push;
    logic             w_ovf;
    logic             w_chmis;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_data;

    // Offer only in RUN with a non-empty list; idx is forced to 0 when idle
    assign w_vld   = w_run && (r_count != '0);
    assign w_pop   = w_vld && bus.alloc_rdy[c];
    assign w_own   = (bus.release_idx[c][IDX_W-1 -: CHW] == CHW'(c));
    assign w_rel   = w_run && bus.release_vld[c];
    // A pop in the same cycle frees the slot, so a full channel may still accept
    assign w_push  = w_rel && w_own && ((r_count < CW'(EPC)) || w_pop);
    assign w_ovf   = w_rel && w_own && (r_count == CW'(EPC)) && !w_pop;
    assign w_chmis = w_rel && !w_own;

    assign w_wr_en   = w_init || w_push;
    assign w_wr_data = w_init ? {CHW'(c), r_init_cnt} : bus.release_idx[c];

    assign bus.alloc_vld[c] = w_vld;
    assign bus.alloc_idx[c] = w_vld ? r_fifo[r_rd_ptr] : '0;
    assign free_cnt[c]      = r_count;
    assign err_overflow[c]  = r_err_ovf;
    assign err_chmis[c]     = r_err_chmis;

    // Pointers, occupancy and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_rd_ptr    <= '0;
        r_wr_ptr    <= '0;
        r_count     <= '0;
        r_err_ovf   <= 1'b0;
        r_err_chmis <= 1'b0;
      end else begin
        if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_wr_en && !w_pop)      r_count <= r_count + CW'(1);
        else if (!w_wr_en && w_pop) r_count <= r_count - CW'(1);
        if (w_ovf)   r_err_ovf   <= 1'b1;
        if (w_chmis) r_err_chmis <= 1'b1;
      end
    end

    // Free-index storage; contents are rewritten by INIT after every reset
    always_ff @(posedge clk) begin
      if (w_wr_en) r_fifo[r_wr_ptr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_wdb_entry_alloc.sv
// Directed bench for wdb_entry_alloc: init, drain, recycle order,
// simultaneous pop/push, error flags and mid-operation reset.
module tb_wdb_entry_alloc;
  logic clk;
  logic rst_n;
  logic [3:0][4:0] free_cnt;
  logic            init_done;
  logic [3:0]      err_overflow;
  logic [3:0]      err_chmis;
  int n_checks;
  int n_fail;

  wdb_entry_alloc_if #(.IDX_W(6), .CH_NUM(4)) bus ();

  wdb_entry_alloc #(.DB_ENTRY_NUM(64), .CH_NUM(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .free_cnt     (free_cnt),
    .init_done    (init_done),
    .err_overflow (err_overflow),
    .err_chmis    (err_chmis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.alloc_rdy   = 4'h0;
    bus.release_vld = 4'h0;
    bus.release_idx = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.alloc_vld !== 4'h0 || bus.alloc_idx !== 24'h0) begin
      n_fail++; $display("FAIL reset_alloc: vld=%h idx=%h required vld=0 idx=0", bus.alloc_vld, bus.alloc_idx);
    end
    n_checks++;
    if (free_cnt !== 20'h0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: free_cnt=%h init_done=%b required 0 0", free_cnt, init_done);
    end
    n_checks++;
    if (err_overflow !== 4'h0 || err_chmis !== 4'h0) begin
      n_fail++; $display("FAIL reset_err: ovf=%h chmis=%h required 0 0", err_overflow, err_chmis);
    end
  endtask

  // Releases and alloc_rdy during INIT must be ignored without raising errors
  task automatic test_init();
    rst_n = 1'b1;
    bus.alloc_rdy   = 4'hF;
    bus.release_vld = 4'hF;
    bus.release_idx = {4{6'd63}};
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 10) idle_inputs();
      if (k == 8) begin
        n_checks++;
        if (free_cnt !== {4{5'd8}} || bus.alloc_vld !== 4'h0) begin
          n_fail++; $display("FAIL init_mid: free_cnt=%h vld=%h required 08080808-style 8s and vld=0", free_cnt, bus.alloc_vld);
        end
      end
      if (k == 15) begin
        n_checks++;
        if (init_done !== 1'b0) begin
          n_fail++; $display("FAIL init_early: init_done=%b required 0", init_done);
        end
      end
    end
    n_checks++;
    if (init_done !== 1'b1) begin
      n_fail++; $display("FAIL init_done: init_done=%b required 1", init_done);
    end
    n_checks++;
    if (free_cnt !== {4{5'd16}}) begin
      n_fail++; $display("FAIL init_free: free_cnt=%h required 16 on all", free_cnt);
    end
    n_checks++;
    if (bus.alloc_vld !== 4'hF || bus.alloc_idx !== {6'd48, 6'd32, 6'd16, 6'd0}) begin
      n_fail++; $display("FAIL init_alloc: vld=%h idx=%h required F and 48/32/16/0", bus.alloc_vld, bus.alloc_idx);
    end
    n_checks++;
    if (err_chmis !== 4'h0 || err_overflow !== 4'h0) begin
      n_fail++; $display("FAIL init_err: chmis=%h ovf=%h required 0 0", err_chmis, err_overflow);
    end
  endtask

  task automatic test_drain();
    bus.alloc_rdy = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (bus.alloc_vld[1] !== 1'b1 || bus.alloc_idx[1] !== 6'(16 + i)) begin
        n_fail++; $display("FAIL drain_step%0d: vld=%b idx=%0d required 1 %0d", i, bus.alloc_vld[1], bus.alloc_idx[1], 16 + i);
      end
      @(negedge clk);
    end
    bus.alloc_rdy = 4'h0;
    n_checks++;
    if (bus.alloc_vld !== 4'b1101 || free_cnt[1] !== 5'd0) begin
      n_fail++; $display("FAIL drain_empty: vld=%h free1=%0d required D 0", bus.alloc_vld, free_cnt[1]);
    end
    n_checks++;
    if (free_cnt[0] !== 5'd16 || free_cnt[2] !== 5'd16 || free_cnt[3] !== 5'd16 || bus.alloc_idx[3] !== 6'd48) begin
      n_fail++; $display("FAIL drain_others: free_cnt=%h idx3=%0d required 16s and 48", free_cnt, bus.alloc_idx[3]);
    end
  endtask

  task automatic test_recycle();
    bus.alloc_rdy = 4'b0100;
    repeat (16) @(negedge clk);
    bus.alloc_rdy = 4'h0;
    n_checks++;
    if (bus.alloc_vld[2] !== 1'b0 || free_cnt[2] !== 5'd0) begin
      n_fail++; $display("FAIL recycle_empty: vld2=%b free2=%0d required 0 0", bus.alloc_vld[2], free_cnt[2]);
    end
    bus.release_vld    = 4'b0100;
    bus.release_idx[2] = 6'd40;
    #1;
    n_checks++;
    if (bus.alloc_vld[2] !== 1'b0) begin
      n_fail++; $display("FAIL recycle_bypass: vld2=%b required 0", bus.alloc_vld[2]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alloc_vld[2] !== 1'b1 || bus.alloc_idx[2] !== 6'd40) begin
      n_fail++; $display("FAIL recycle_rise: vld2=%b idx2=%0d required 1 40", bus.alloc_vld[2], bus.alloc_idx[2]);
    end
    bus.release_idx[2] = 6'd35;
    @(negedge clk);
    bus.release_idx[2] = 6'd47;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (free_cnt[2] !== 5'd3) begin
      n_fail++; $display("FAIL recycle_count: free2=%0d required 3", free_cnt[2]);
    end
    bus.alloc_rdy = 4'b0100;
    n_checks++;
    if (bus.alloc_idx[2] !== 6'd40) begin
      n_fail++; $display("FAIL recycle_order0: idx2=%0d required 40", bus.alloc_idx[2]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alloc_idx[2] !== 6'd35) begin
      n_fail++; $display("FAIL recycle_order1: idx2=%0d required 35", bus.alloc_idx[2]);
    end
    @(negedge clk);
    n_checks++;
    if (bus.alloc_idx[2] !== 6'd47) begin
      n_fail++; $display("FAIL recycle_order2: idx2=%0d required 47", bus.alloc_idx[2]);
    end
    @(negedge clk);
    bus.alloc_rdy = 4'h0;
    n_checks++;
    if (bus.alloc_vld[2] !== 1'b0 || free_cnt[2] !== 5'd0) begin
      n_fail++; $display("FAIL recycle_end: vld2=%b free2=%0d required 0 0", bus.alloc_vld[2], free_cnt[2]);
    end
  endtask

  // Channel 0: take idx 0, return it (full again), then pop idx 1 and
  // return it in the same cycle while full
  task automatic test_simultaneous();
    bus.alloc_rdy = 4'b0001;
    @(negedge clk);
    bus.alloc_rdy      = 4'h0;
    bus.release_vld    = 4'b0001;
    bus.release_idx[0] = 6'd0;
    @(negedge clk);
    n_checks++;
    if (free_cnt[0] !== 5'd16 || bus.alloc_idx[0] !== 6'd1) begin
      n_fail++; $display("FAIL simul_refill: free0=%0d idx0=%0d required 16 1", free_cnt[0], bus.alloc_idx[0]);
    end
    bus.alloc_rdy      = 4'b0001;
    bus.release_idx[0] = 6'd1;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (free_cnt[0] !== 5'd16 || err_overflow[0] !== 1'b0) begin
      n_fail++; $display("FAIL simul_full: free0=%0d ovf0=%b required 16 0", free_cnt[0], err_overflow[0]);
    end
    n_checks++;
    if (bus.alloc_idx[0] !== 6'd2 || bus.alloc_vld[0] !== 1'b1) begin
      n_fail++; $display("FAIL simul_head: idx0=%0d vld0=%b required 2 1", bus.alloc_idx[0], bus.alloc_vld[0]);
    end
  endtask

  task automatic test_errors();
    bus.release_vld    = 4'b1000;
    bus.release_idx[3] = 6'd20;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (err_chmis !== 4'b1000 || free_cnt[3] !== 5'd16 || err_overflow !== 4'h0) begin
      n_fail++; $display("FAIL err_chmis: chmis=%h free3=%0d ovf=%h required 8 16 0", err_chmis, free_cnt[3], err_overflow);
    end
    bus.release_vld    = 4'b0001;
    bus.release_idx[0] = 6'd3;
    @(negedge clk);
    idle_inputs();
    n_checks++;
    if (err_overflow !== 4'b0001 || free_cnt[0] !== 5'd16 || bus.alloc_idx[0] !== 6'd2) begin
      n_fail++; $display("FAIL err_ovf: ovf=%h free0=%0d idx0=%0d required 1 16 2", err_overflow, free_cnt[0], bus.alloc_idx[0]);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_overflow !== 4'b0001 || err_chmis !== 4'b1000) begin
      n_fail++; $display("FAIL err_sticky: ovf=%h chmis=%h required 1 8", err_overflow, err_chmis);
    end
  endtask

  task automatic test_midop_reset();
    bus.alloc_rdy = 4'b0001;
    repeat (9) @(negedge clk);
    bus.alloc_rdy = 4'h0;
    n_checks++;
    if (free_cnt[0] !== 5'd7 || bus.alloc_vld[0] !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: free0=%0d vld0=%b required 7 1", free_cnt[0], bus.alloc_vld[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.alloc_vld !== 4'h0 || free_cnt !== 20'h0 || init_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_async: vld=%h free_cnt=%h init_done=%b required 0 0 0", bus.alloc_vld, free_cnt, init_done);
    end
    n_checks++;
    if (err_overflow !== 4'h0 || err_chmis !== 4'h0) begin
      n_fail++; $display("FAIL mid_err: ovf=%h chmis=%h required 0 0", err_overflow, err_chmis);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    n_checks++;
    if (init_done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reinit_early: init_done=%b required 0", init_done);
    end
    @(negedge clk);
    n_checks++;
    if (init_done !== 1'b1 || free_cnt !== {4{5'd16}}) begin
      n_fail++; $display("FAIL mid_reinit: init_done=%b free_cnt=%h required 1 and 16s", init_done, free_cnt);
    end
    n_checks++;
    if (bus.alloc_idx !== {6'd48, 6'd32, 6'd16, 6'd0} || bus.alloc_vld !== 4'hF) begin
      n_fail++; $display("FAIL mid_idx: idx=%h vld=%h required 48/32/16/0 F", bus.alloc_idx, bus.alloc_vld);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_init();
    test_drain();
    test_recycle();
    test_simultaneous();
    test_errors();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
